ad9516_spi_ctrl: RTL
====================

Name: ad9516_spi_ctrl

Overview:
- Single-transaction SPI master for the AD9516 clock chip, 4-wire mode.
- Sits directly downstream of the edge-to-single-pulse stage. That stage's one-cycle pulse is this block's `start` strobe.
- Each accepted `start` issues one 24-bit frame: a 16-bit instruction followed by 1 data byte, MSB first.
- Writes drive `wdata` onto the bus. Reads capture the returned byte into `rdata`.

Parameters:
- CLK_DIV, 4, SCLK half-period in `clk` cycles. Legal range is 1 or more; SCLK = clk / (2*CLK_DIV).
- ADDR_W, 13, AD9516 register address width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request pulse.
- rw  in  1  1 = read, 0 = write. Sampled with `start`.
- addr  in  ADDR_W  register address. Sampled with `start`.
- wdata  in  8  write byte. Sampled with `start`.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  last byte read.
- spi_cs_n  out  1  chip select, active low.
- spi_sclk  out  1  serial clock; idles low.
- spi_sdio  out  1  serial data out.
- spi_sdo  in  1  serial data in from the AD9516.

Behaviour:
- Reset values: busy=0, done=0, rdata=8'h00, spi_cs_n=1, spi_sclk=0, spi_sdio=0, FSM=IDLE. Reset is asynchronous and may be asserted mid-frame; the frame is abandoned with no done pulse.
- Frame layout: {rw, 2'b00 (W1W0 = one byte), addr[12:0], byte[7:0]}.
  - The byte field is wdata for writes and 8'h00 for reads.
  - The frame is latched into a 24-bit shift register on the cycle `start` is accepted.
- States:
  - IDLE: waits for `start`.
  - SHIFT: clocks out the 24 bits.
  - HOLD: keeps cs_n low after the last clock.
  - DONE: completion cycle.
- Timing, with D = CLK_DIV and T0 = the edge at which `start`=1 is sampled in IDLE:
  - T1: spi_cs_n=0, busy=1, spi_sdio = frame bit 23.
  - Each bit lasts 2D cycles: D cycles with spi_sclk=0, then D cycles with spi_sclk=1.
  - spi_sdio changes only on the first cycle of a bit's low phase. The AD9516 samples it on the SCLK rise.
  - All 24 bits occupy T1 .. T1+48D-1.
  - HOLD occupies T1+48D .. T1+49D-1, with spi_sclk=0 and spi_cs_n=0.
  - DONE occupies T1+49D: spi_cs_n=1, done=1, busy=0, spi_sdio=0. The next cycle returns to IDLE.
- Read capture:
  - For read frames, spi_sdo is sampled on the last clk cycle of each high phase of bits 7..0 and shifted into a capture register, MSB first.
  - `rdata` updates in the DONE cycle.
  - Write frames leave `rdata` unchanged.
- `start` handling:
  - `start` outside IDLE (SHIFT, HOLD or DONE) is ignored: no queueing and no effect on the current frame.
  - Minimum spacing between accepted `start`s is therefore 49D+2 cycles.
- Input stability: inputs other than `start` are don't-care outside the accepting cycle.
- Counters:
  - A divider counter counts 0..D-1 and toggles the phase.
  - A bit counter counts 23..0.
  - Widths are sized with $clog2. The D=1 case must work with no off-by-one.
- Bus idle state: spi_sclk never toggles while spi_cs_n=1.

Decomposition:
- Package `ad9516_pkg`:
  - ADDR_W=13, FRAME_W=24, INSTR_W=16.
  - W1W0_ONE_BYTE=2'b00.
  - FSM state enum: IDLE, SHIFT, HOLD, DONE.
- Sub-module `ad9516_sclk_gen`:
  - Half-period counter.
  - Emits `rise_en` and `fall_en` strobes and the `spi_sclk` level.
  - Enabled by the parent FSM and reset to sclk=0.

Test Plan:
- Write, D=2: start with rw=0, addr=13'h010, wdata=8'h7C.
  - -> Serial frame decoded at SCLK rises = 24'h00107C.
  - -> cs_n low for exactly 98 cycles.
  - -> done at T0+99; rdata unchanged (00).
- Read, D=2: rw=1, addr=13'h000; the SDO model drives 8'h18 on SCLK falls during the data byte.
  - -> Instruction decoded = 16'h8000.
  - -> rdata=8'h18 in the done cycle.
  - -> busy=1 from T1 to T0+98.
- Ignored start: pulse `start` at T1+10 and again in the DONE cycle, with different addr.
  - -> Only one frame is sent, decoded 24'h00107C.
  - -> A single done pulse; the second request is lost.
- Reset mid-frame: assert rst_n=0 after 12 bits.
  - -> Same cycle: cs_n=1, sclk=0, sdio=0, busy=0; no done.
  - -> After release, a new write of addr=13'h232, wdata=8'h01 decodes as 24'h023201.
- Back-to-back, D=1: accept a start on the first IDLE cycle after done.
  - -> Each frame is 24 SCLK periods of 2 cycles.
  - -> cs_n high for exactly 2 cycles between frames.
  - -> Both frames are decoded correctly.

Source files
------------

// File: rtl/ad9516_pkg.sv
// Shared constants, state encoding and frame packing for the AD9516 SPI master.
package ad9516_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned FRAME_W = 24;
  localparam int unsigned INSTR_W = 16;

  localparam logic [1:0] W1W0_ONE_BYTE = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold,
    StDone
  } spi_state_e;

  // Instruction word followed by the data byte; reads send a zero byte.
  function automatic logic [FRAME_W-1:0] build_frame(input logic              rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [7:0]        wdata);
    return {rw, W1W0_ONE_BYTE, addr, (rw ? 8'h00 : wdata)};
  endfunction

endpackage

// File: rtl/ad9516_sclk_gen.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled, toggling SCLK when allowed.
module ad9516_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic toggle_en,
  output logic tick,
  output logic rise_en,
  output logic fall_en,
  output logic spi_sclk
);

  localparam int unsigned     CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sclk_q;

  // Strobes flag the last cycle of a half period; the toggle lands on the following edge.
  always_comb begin
    tick     = en && (cnt_q == CNT_MAX);
    rise_en  = tick && toggle_en && !sclk_q;
    fall_en  = tick && toggle_en && sclk_q;
    spi_sclk = sclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (rise_en || fall_en) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/ad9516_spi_ctrl.sv
// Single-transaction 4-wire SPI master for the AD9516: one 24-bit frame per start pulse.
module ad9516_spi_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = ad9516_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_sdio,
  input  logic              spi_sdo
);

  import ad9516_pkg::*;

  localparam int unsigned BIT_W = $clog2(FRAME_W);

  spi_state_e         state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [FRAME_W-1:0] frame;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [7:0]         cap_q;
  logic [7:0]         rdata_q;
  logic               rw_q;
  logic               sdio_q;
  logic               cs_n_q;
  logic               busy_q;
  logic               done_q;

  logic gen_en;
  logic gen_toggle;
  logic tick;
  logic rise_en;
  logic fall_en;

  always_comb begin
    frame      = build_frame(rw, addr, wdata);
    // The divider keeps running through HOLD to time it, but SCLK stays parked low.
    gen_en     = (state_q == StShift) || (state_q == StHold);
    gen_toggle = (state_q == StShift);
  end

  ad9516_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (gen_en),
    .toggle_en (gen_toggle),
    .tick      (tick),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .spi_sclk  (spi_sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      sdio_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q   <= frame;
            sdio_q    <= frame[FRAME_W-1];
            rw_q      <= rw;
            bit_cnt_q <= BIT_W'(FRAME_W - 1);
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          // fall_en marks the last high cycle of a bit: sample SDO, then advance SDIO.
          if (fall_en) begin
            if (rw_q && (bit_cnt_q < BIT_W'(8))) begin
              cap_q <= {cap_q[6:0], spi_sdo};
            end
            if (bit_cnt_q == '0) begin
              state_q <= StHold;
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
              shreg_q   <= {shreg_q[FRAME_W-2:0], 1'b0};
              sdio_q    <= shreg_q[FRAME_W-2];
            end
          end
        end
        StHold: begin
          if (tick) begin
            if (rw_q) begin
              rdata_q <= cap_q;
            end
            sdio_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy     = busy_q;
    done     = done_q;
    rdata    = rdata_q;
    spi_cs_n = cs_n_q;
    spi_sdio = sdio_q;
  end

endmodule
